nn_spike_scheduler: RTL and testbench

Event scheduler in front of the neuron–synapse array. It accepts synapse-ID events from two requesters through valid/ready handshakes and arbitrates between them round-robin. Events are buffered in a FIFO and played out one at a time on `syn_addr`, each with a fixed-width strobe and a guard gap. It sits between the Wishbone NN register block (requester A), the logic-analyzer/test path (requester B) and the array's `syn_addr` input, all on `wb_clk_i`.

---
 rtl/nn_spike_scheduler.sv | 178 +++++++++++++++++
 tb/tb_nn_spike_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_spike_scheduler.sv
// Round-robin event scheduler: two valid/ready requesters feed a FIFO that is played
// out on syn_addr/syn_en with a fixed strobe width and guard gap. Option: NN_SCHED_STATS_EN.
module nn_spike_scheduler #(
    parameter int unsigned ID_W        = 8,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     a_valid,
    input  logic [ID_W-1:0]          a_id,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [ID_W-1:0]          b_id,
    output logic                     b_ready,
    input  logic                     sched_en,
    input  logic                     flush,
    output logic [ID_W-1:0]          syn_addr,
    output logic                     syn_en,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
`ifdef NN_SCHED_STATS_EN
    ,
    output logic [15:0]              evt_count,
    output logic [15:0]              drop_stall
`endif
);

    localparam int unsigned PW        = $clog2(DEPTH);
    localparam int unsigned LW        = PW + 1;
    localparam int unsigned CNT_MAX   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [ID_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            last_grant_b;
    logic            full_c;
    logic            empty_c;
    logic            grant_a_c;
    logic            grant_b_c;
    logic            push_c;
    logic            pop_c;
    logic [ID_W-1:0] push_id_c;

    assign full_c    = (level == LW'(DEPTH));
    assign empty_c   = (level == '0);
    assign push_c    = grant_a_c | grant_b_c;
    assign push_id_c = grant_a_c ? a_id : b_id;
    // flush suppresses the pop, so no new event starts in a flush cycle
    assign pop_c     = (state == IDLE) && sched_en && !empty_c && !flush;
    assign a_ready   = grant_a_c;
    assign b_ready   = grant_b_c;
    assign busy      = (state != IDLE) || !empty_c;

    // Round-robin arbiter: on contention the requester not granted last time wins
    always_comb begin
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        if (!full_c && !flush) begin
            if (a_valid && b_valid) begin
                grant_a_c = last_grant_b;
                grant_b_c = !last_grant_b;
            end else begin
                grant_a_c = a_valid;
                grant_b_c = b_valid;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_c) begin
            mem[wr_ptr] <= push_id_c;
        end
    end

    // Pointers, occupancy and arbitration history
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            last_grant_b <= 1'b1;
        end else begin
            if (grant_a_c) begin
                last_grant_b <= 1'b0;
            end else if (grant_b_c) begin
                last_grant_b <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push_c) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                level <= level + LW'(push_c) - LW'(pop_c);
            end
        end
    end

    // Playout FSM: IDLE -> DRIVE (HOLD_CYCLES) -> GAP (GAP_CYCLES) -> IDLE
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            syn_en   <= 1'b0;
            syn_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        syn_addr <= mem[rd_ptr];
                        syn_en   <= 1'b1;
                        cnt      <= HOLD_LOAD;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        syn_en <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            cnt   <= GAP_LOAD;
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    syn_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef NN_SCHED_STATS_EN
    // Saturating event and full-stall counters
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            evt_count  <= '0;
            drop_stall <= '0;
        end else if (flush) begin
            evt_count  <= '0;
            drop_stall <= '0;
        end else begin
            if (pop_c && (evt_count != 16'hFFFF)) begin
                evt_count <= evt_count + 16'd1;
            end
            if ((a_valid || b_valid) && full_c && (drop_stall != 16'hFFFF)) begin
                drop_stall <= drop_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nn_spike_scheduler.sv
// Self-checking bench for nn_spike_scheduler: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_nn_spike_scheduler;

    localparam int unsigned ID_W  = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned GAP   = 2;

    logic            clk;
    logic            rst;
    logic            a_valid, b_valid, a_ready, b_ready;
    logic [ID_W-1:0] a_id, b_id;
    logic            sched_en, flush;
    logic [ID_W-1:0] syn_addr;
    logic            syn_en, busy;
    logic [3:0]      level;
`ifdef NN_SCHED_STATS_EN
    logic [15:0]     evt_count, drop_stall;
`endif

    nn_spike_scheduler #(
        .ID_W(ID_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .a_valid(a_valid), .a_id(a_id), .a_ready(a_ready),
        .b_valid(b_valid), .b_id(b_id), .b_ready(b_ready),
        .sched_en(sched_en), .flush(flush),
        .syn_addr(syn_addr), .syn_en(syn_en), .busy(busy), .level(level)
`ifdef NN_SCHED_STATS_EN
        , .evt_count(evt_count), .drop_stall(drop_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: FIFO as a queue, event progress as cycles remaining until idle
    logic [7:0] mq[$];
    int         rem;
    logic       m_last_b;
    logic [7:0] m_addr;
    logic       m_ga, m_gb;
    int         m_evt, m_stall;

    logic       s_ar, s_br, s_en;
    logic [7:0] s_addr;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rem      = 0;
        m_last_b = 1'b1;
        m_addr   = 8'h00;
        m_evt    = 0;
        m_stall  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_id = 8'h00; b_id = 8'h00;
        sched_en = 1'b0; flush = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_syn_en", int'(syn_en), 0);
        chk("rst_syn_addr", int'(syn_addr), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
    endtask

    // One clock: drive at negedge, check handshake before the edge, check outputs after it
    task automatic step(input logic av, input logic [7:0] aid, input logic bv,
                        input logic [7:0] bid, input logic se, input logic fl);
        logic full;
        logic pop;
        a_valid = av; a_id = aid; b_valid = bv; b_id = bid;
        sched_en = se; flush = fl;
        full = (mq.size() == int'(DEPTH));
        m_ga = 1'b0;
        m_gb = 1'b0;
        if (!full && !fl) begin
            if (av && bv) begin
                m_ga = m_last_b;
                m_gb = !m_last_b;
            end else begin
                m_ga = av;
                m_gb = bv;
            end
        end
        pop = (rem == 0) && se && (mq.size() != 0) && !fl;
        #1;
        s_ar = a_ready;
        s_br = b_ready;
        chk("a_ready", int'(s_ar), int'(m_ga));
        chk("b_ready", int'(s_br), int'(m_gb));
        @(posedge clk);
        if (fl) begin
            m_evt = 0;
            m_stall = 0;
        end else begin
            if (pop && m_evt < 65535) m_evt++;
            if ((av || bv) && full && m_stall < 65535) m_stall++;
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) m_addr = mq.pop_front();
            if (m_ga) mq.push_back(aid);
            if (m_gb) mq.push_back(bid);
        end
        if (m_ga) m_last_b = 1'b0;
        if (m_gb) m_last_b = 1'b1;
        if (pop) rem = int'(HOLD + GAP);
        else if (rem > 0) rem--;
        #1;
        s_en = syn_en;
        s_addr = syn_addr;
        chk("syn_en", int'(s_en), (rem > int'(GAP)) ? 1 : 0);
        chk("syn_addr", int'(s_addr), int'(m_addr));
        chk("level", int'(level), mq.size());
        chk("busy", int'(busy), (rem > 0 || mq.size() != 0) ? 1 : 0);
`ifdef NN_SCHED_STATS_EN
        chk("evt_count", int'(evt_count), m_evt);
        chk("drop_stall", int'(drop_stall), m_stall);
`endif
        @(negedge clk);
    endtask

    typedef struct {
        logic       av;
        logic [7:0] aid;
        logic       bv;
        logic [7:0] bid;
        logic       se;
        logic       fl;
        logic       ar;
        logic       br;
        logic [3:0] lvl;
        logic       en;
        logic [7:0] addr;
        logic       bsy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [7:0] exp_seq[6];
        logic [7:0] seq[6];
        int         t_rise[6];
        int         nr, na, nb, ai, bi, pushed, en_cycles, rises;
        logic       prev;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;

        // Single event, then contention with A granted last, then push+pop in one cycle
        tbl[0] = '{1'b1, 8'h2A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h2A, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h2A, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h2A, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h2A, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h2A, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h2A, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h2A, 1'b0};
        tbl[8] = '{1'b1, 8'h05, 1'b1, 8'h85, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 8'h2A, 1'b1};
        tbl[9] = '{1'b1, 8'h05, 1'b1, 8'h85, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 8'h85, 1'b1};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].av, tbl[i].aid, tbl[i].bv, tbl[i].bid, tbl[i].se, tbl[i].fl);
            chk("tbl_a_ready", int'(s_ar), int'(tbl[i].ar));
            chk("tbl_b_ready", int'(s_br), int'(tbl[i].br));
            chk("tbl_level", int'(level), int'(tbl[i].lvl));
            chk("tbl_syn_en", int'(s_en), int'(tbl[i].en));
            chk("tbl_syn_addr", int'(s_addr), int'(tbl[i].addr));
            chk("tbl_busy", int'(busy), int'(tbl[i].bsy));
        end

        // Contention: alternating grants, playout order and 7-cycle period
        do_reset();
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h81; exp_seq[2] = 8'h02;
        exp_seq[3] = 8'h82; exp_seq[4] = 8'h03; exp_seq[5] = 8'h83;
        ai = 1; bi = 8'h81; na = 0; nb = 0; nr = 0; prev = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step(na < 3, 8'(ai), nb < 3, 8'(bi), 1'b1, 1'b0);
            if (m_ga) begin na++; ai++; end
            if (m_gb) begin nb++; bi++; end
            if (s_en && !prev && nr < 6) begin
                seq[nr] = s_addr;
                t_rise[nr] = c;
                nr++;
            end
            prev = s_en;
        end
        chk("cont_events", nr, 6);
        for (int i = 0; i < nr; i++) begin
            chk("cont_addr", int'(seq[i]), int'(exp_seq[i]));
            if (i > 0) chk("cont_period", t_rise[i] - t_rise[i-1], int'(HOLD + GAP + 1));
        end

        // Full: 9th push refused until the first pop frees a slot
        do_reset();
        pushed = 0;
        for (int c = 0; c < 9; c++) begin
            step(1'b1, 8'(8'h40 + pushed), 1'b0, 8'h00, 1'b0, 1'b0);
            if (m_ga) pushed++;
        end
        chk("full_level", int'(level), 8);
        chk("full_9th_ready", int'(s_ar), 0);
        step(1'b1, 8'h48, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_pop_cycle_ready", int'(s_ar), 0);
        chk("full_after_pop_level", int'(level), 7);
        step(1'b1, 8'h48, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_retry_ready", int'(s_ar), 1);
        repeat (80) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

        // Flush during DRIVE: current event completes, no further events
        do_reset();
        for (int c = 0; c < 6; c++) step(1'b1, 8'(8'h10 + c), 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_pre_level", int'(level), 5);
        en_cycles = int'(s_en);
        rises = int'(s_en);
        prev = s_en;
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("flush_level", int'(level), 0);
        en_cycles += int'(s_en);
        prev = s_en;
        for (int c = 0; c < 25; c++) begin
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
            en_cycles += int'(s_en);
            if (s_en && !prev) rises++;
            prev = s_en;
        end
        chk("flush_en_cycles", en_cycles, int'(HOLD));
        chk("flush_rises", rises, 1);

        // Asynchronous reset mid-DRIVE, then A wins first contention
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b1, 8'(8'h3C + c), 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_syn_en", int'(syn_en), 0);
        chk("arst_syn_addr", int'(syn_addr), 0);
        chk("arst_level", int'(level), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0);
        chk("arst_first_grant_a", int'(s_ar), 1);
        chk("arst_first_grant_b", int'(s_br), 0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                 ($urandom % 6) != 0, ($urandom % 40) == 0);
        end

`ifdef NN_SCHED_STATS_EN
        // Stats: three played events, ten stalled cycles while full
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b1, 8'(c + 1), 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (30) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("stats_evt_count", int'(evt_count), 3);
        for (int c = 0; c < 8; c++) step(1'b1, 8'(c), 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (10) step(1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("stats_drop_stall", int'(drop_stall), 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
